// File: rtl/input_port_conditioner.sv
// Button input conditioning: two-flop synchronizer, per-bit debounce,
// edge events and software-clearable sticky press flags for the port E word.
module input_port_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] rawInput,
    input  logic             clearStrobe,
    input  logic [WIDTH-1:0] clearMask,
    output logic [WIDTH-1:0] stableState,
    output logic [WIDTH-1:0] pressEvent,
    output logic [WIDTH-1:0] releaseEvent,
    output logic [WIDTH-1:0] pressLatched,
    output logic [31:0]      portWord
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q,  stable_d;
    logic [WIDTH-1:0] press_q,   press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] latched_q, latched_d;
    logic [WIDTH-1:0] accept;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A sample agreeing with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync2_q[i];
                accept[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        press_d   = accept & sync2_q;
        release_d = accept & ~sync2_q;
        // Set is OR'd after the clear so a same-edge press is never lost.
        latched_d = (latched_q & ~({WIDTH{clearStrobe}} & clearMask))
                  | press_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            latched_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= rawInput;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            latched_q <= latched_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stableState  = stable_q;
    assign pressEvent   = press_q;
    assign releaseEvent = release_q;
    assign pressLatched = latched_q;

    always_comb begin
        portWord                = '0;
        portWord[WIDTH-1:0]     = stable_q;
        portWord[16 +: WIDTH]   = latched_q;
    end

endmodule

// File: tb/tb_input_port_conditioner.sv
// Directed bench for input_port_conditioner, WIDTH=4, DEBOUNCE_CYCLES=4.
// Expected values are hand-derived edge counts from the input change.
module tb_input_port_conditioner;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  rawInput;
    logic        clearStrobe;
    logic [3:0]  clearMask;
    logic [3:0]  stableState;
    logic [3:0]  pressEvent;
    logic [3:0]  releaseEvent;
    logic [3:0]  pressLatched;
    logic [31:0] portWord;

    int n_run  = 0;
    int n_fail = 0;

    input_port_conditioner #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rawInput(rawInput),
        .clearStrobe(clearStrobe),
        .clearMask(clearMask),
        .stableState(stableState),
        .pressEvent(pressEvent),
        .releaseEvent(releaseEvent),
        .pressLatched(pressLatched),
        .portWord(portWord)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] raw);
        reset    = 1'b1;
        rawInput = raw;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [3:0] acc;
    int         cnt;
    int         at;
    logic [8:0] pat;

    initial begin
        reset       = 1'b0;
        rawInput    = '0;
        clearStrobe = 1'b0;
        clearMask   = '0;
        @(negedge clock);

        // Reset with all buttons held
        do_reset(4'hF);
        chk("rst_stable", 32'(stableState), 32'h0);
        chk("rst_press", 32'(pressEvent), 32'h0);
        chk("rst_release", 32'(releaseEvent), 32'h0);
        chk("rst_latched", 32'(pressLatched), 32'h0);
        chk("rst_word", portWord, 32'h0);
        repeat (5) step();
        chk("rst_e4_stable", 32'(stableState), 32'h0);
        step();
        chk("rst_e5_stable", 32'(stableState), 32'hF);
        chk("rst_e5_press", 32'(pressEvent), 32'hF);
        chk("rst_e5_latched", 32'(pressLatched), 32'hF);
        chk("rst_e5_word", portWord, 32'h000F_000F);
        step();
        chk("rst_e6_press", 32'(pressEvent), 32'h0);
        chk("rst_e6_latched", 32'(pressLatched), 32'hF);

        // Glitch rejection: 3-cycle pulse never accepted
        do_reset(4'h0);
        acc = '0;
        rawInput = 4'b0001;
        for (int e = 0; e < 12; e++) begin
            if (e == 3) rawInput = 4'b0000;
            step();
            acc |= stableState | pressEvent | pressLatched;
        end
        chk("glitch_none", 32'(acc), 32'h0);

        // 4-cycle hold accepted exactly at edge 5
        rawInput = 4'b0001;
        for (int e = 0; e < 5; e++) begin
            if (e == 4) rawInput = 4'b0000;
            step();
        end
        chk("hold_e4_stable", 32'(stableState), 32'h0);
        step();
        chk("hold_e5_stable", 32'(stableState), 32'h1);
        chk("hold_e5_press", 32'(pressEvent), 32'h1);
        repeat (10) step();
        chk("hold_released", 32'(stableState), 32'h0);
        chk("hold_latched", 32'(pressLatched), 32'h1);

        // Bounce on bit 2: pattern 1,0,1,1,0,1,1,1,1 then held
        do_reset(4'h0);
        pat = 9'b1_1110_1101;
        cnt = 0;
        at  = -1;
        for (int e = 0; e < 16; e++) begin
            rawInput = (e < 9) ? {1'b0, pat[e], 2'b00} : 4'b0100;
            step();
            if (pressEvent[2]) begin
                cnt++;
                at = e;
            end
        end
        chk("bounce_count", 32'(cnt), 32'd1);
        chk("bounce_edge", 32'(at), 32'd10);
        chk("bounce_stable", 32'(stableState), 32'h4);

        // Release of bit 1
        do_reset(4'h0);
        rawInput = 4'b0010;
        repeat (8) step();
        chk("rel_pre_stable", 32'(stableState), 32'h2);
        rawInput = 4'b0000;
        cnt = 0;
        at  = -1;
        for (int e = 0; e < 10; e++) begin
            step();
            if (releaseEvent[1]) begin
                cnt++;
                at = e;
            end
        end
        chk("rel_count", 32'(cnt), 32'd1);
        chk("rel_edge", 32'(at), 32'd5);
        chk("rel_stable", 32'(stableState), 32'h0);
        chk("rel_latched", 32'(pressLatched), 32'h2);

        // Clear colliding with a bit-0 press
        do_reset(4'h0);
        rawInput = 4'b0011;
        repeat (8) step();
        rawInput = 4'b0010;
        repeat (8) step();
        chk("clr_pre_stable", 32'(stableState), 32'h2);
        rawInput = 4'b0011;
        repeat (5) step();
        chk("clr_pre_latched", 32'(pressLatched), 32'h3);
        clearStrobe = 1'b1;
        clearMask   = 4'b0011;
        step();
        chk("clr_collide_press", 32'(pressEvent), 32'h1);
        chk("clr_collide_latched", 32'(pressLatched), 32'h1);
        clearMask = 4'b0010;
        step();
        chk("clr_mask_off", 32'(pressLatched), 32'h1);
        clearMask = 4'b0001;
        step();
        chk("clr_final", 32'(pressLatched), 32'h0);
        chk("clr_word", portWord, 32'h0000_0003);
        clearStrobe = 1'b0;
        clearMask   = '0;

        // Reset in the middle of a count
        do_reset(4'h0);
        rawInput = 4'b1000;
        repeat (4) step();
        reset = 1'b1;
        step();
        chk("mid_rst_stable", 32'(stableState), 32'h0);
        reset = 1'b0;
        acc = '0;
        for (int e = 0; e < 5; e++) begin
            step();
            acc |= stableState | pressEvent;
        end
        chk("mid_e4_quiet", 32'(acc), 32'h0);
        step();
        chk("mid_e5_stable", 32'(stableState), 32'h8);
        chk("mid_e5_press", 32'(pressEvent), 32'h8);
        step();
        chk("mid_e6_press", 32'(pressEvent), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
